// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, I-cache address/frame layouts and FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default I-cache geometry: 8 frames of 2 words each.
  localparam int ICACHE_SETS  = 8;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - 3 - ICACHE_IDX_W;

  // Fetch address split at the default geometry.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic                    blkoff;
    logic [1:0]              bytoff;
  } icachef_t;

  // One I-cache frame at the default geometry.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t [1:0]             data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_FILL0 = 2'd1,
    IC_FILL1 = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped I-cache. Combinational read,
// separate write enables for word 0 and word 1; writing word 1 also installs
// the tag and marks the frame valid, so a frame is only valid once complete.
module icache_array
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - 3 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output word_t            rd_data0,
  output word_t            rd_data1,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en0,
  input  logic             wr_en1,
  input  logic [TAG_W-1:0] wr_tag,
  input  word_t            wr_data
);

  logic [SETS-1:0] valid_vec;
  logic [TAG_W-1:0] tag_arr   [SETS];
  word_t            data0_arr [SETS];
  word_t            data1_arr [SETS];

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_frame
      logic             sel;
      logic             valid_q, valid_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      word_t            data0_q, data0_d;
      word_t            data1_q, data1_d;

      assign sel = (wr_idx == IDX_W'(gi));

      // Next frame contents from the per-word write enables.
      always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (sel && wr_en0) begin
          data0_d = wr_data;
        end
        if (sel && wr_en1) begin
          data1_d = wr_data;
          tag_d   = wr_tag;
          valid_d = 1'b1;
        end
      end

      // Frame registers; reset clears everything so abandoned fills stay invalid.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          data0_q <= '0;
          data1_q <= '0;
        end else begin
          valid_q <= valid_d;
          tag_q   <= tag_d;
          data0_q <= data0_d;
          data1_q <= data1_d;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign tag_arr[gi]   = tag_q;
      assign data0_arr[gi] = data0_q;
      assign data1_arr[gi] = data1_q;
    end
  endgenerate

  assign rd_valid = valid_vec[rd_idx];
  assign rd_tag   = tag_arr[rd_idx];
  assign rd_data0 = data0_arr[rd_idx];
  assign rd_data1 = data1_arr[rd_idx];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped read-only instruction cache with a two-beat miss-fill FSM
// toward the bus arbiter, plus saturating hit/miss counters.
module icache_fill_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS      = ICACHE_SETS,
  parameter int BLK_WORDS = 2,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dp_imemREN,
  input  logic [31:0]      dp_imemaddr,
  output logic             dp_ihit,
  output logic [31:0]      dp_imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  icache_state_t    state_q, state_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_word;
  logic [1:0]       unused_bytoff;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  word_t            rd_data0, rd_data1;
  logic             wr_en0, wr_en1;
  logic             hit;

  assign unused_bytoff = dp_imemaddr[1:0];
  assign req_word      = dp_imemaddr[2 +: OFF_W];
  assign req_idx       = dp_imemaddr[2+OFF_W +: IDX_W];
  assign req_tag       = dp_imemaddr[31 -: TAG_W];

  icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .wr_idx   (miss_idx_q),
    .wr_en0   (wr_en0),
    .wr_en1   (wr_en1),
    .wr_tag   (miss_tag_q),
    .wr_data  (iload)
  );

  // Hits are only reported in IDLE, so a frame being replaced never hits.
  always_comb begin
    hit         = (state_q == IC_IDLE) && dp_imemREN && rd_valid && (rd_tag == req_tag);
    dp_ihit     = hit;
    dp_imemload = '0;
    if (hit) begin
      dp_imemload = (req_word != '0) ? rd_data1 : rd_data0;
    end
  end

  // Next state, fill request outputs, array writes and counter updates.
  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    iREN         = 1'b0;
    iaddr        = '0;
    wr_en0       = 1'b0;
    wr_en1       = 1'b0;

    if (hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end

    case (state_q)
      IC_IDLE: begin
        if (dp_imemREN && !hit) begin
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          state_d    = IC_FILL0;
          if (miss_count_q != '1) begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
        end
      end
      IC_FILL0: begin
        iREN  = 1'b1;
        iaddr = {miss_tag_q, miss_idx_q, OFF_W'(0), 2'b00};
        if (!iwait) begin
          wr_en0  = 1'b1;
          state_d = IC_FILL1;
        end
      end
      IC_FILL1: begin
        iREN  = 1'b1;
        iaddr = {miss_tag_q, miss_idx_q, OFF_W'(1), 2'b00};
        if (!iwait) begin
          wr_en1  = 1'b1;
          state_d = IC_IDLE;
        end
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  // State, latched miss address and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IC_IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: fills, hits, conflicts, address change
// mid-fill, reset mid-fill and a long arbiter stall.
module tb_icache_fill_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dp_imemREN = 1'b0;
  logic [31:0] dp_imemaddr = '0;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  icache_fill_ctrl #(
    .SETS      (8),
    .BLK_WORDS (2),
    .CNT_W     (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .dp_imemREN  (dp_imemREN),
    .dp_imemaddr (dp_imemaddr),
    .dp_ihit     (dp_ihit),
    .dp_imemload (dp_imemload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .iwait       (iwait),
    .iload       (iload),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One arbiter beat: iwait high for 'waits' cycles, then low with data.
  task automatic beat(input int waits, input logic [31:0] d, input logic [31:0] exp_addr, input string tag);
    for (int i = 0; i < waits; i++) begin
      iwait = 1'b1;
      #1;
      chk({tag, "_iren_wait"}, 32'(iREN), 32'd1);
      chk({tag, "_iaddr_wait"}, iaddr, exp_addr);
      chk({tag, "_nohit_wait"}, 32'(dp_ihit), 32'd0);
      $display("beat %s wait %0d iaddr=%h", tag, i, iaddr);
      tick();
    end
    iwait = 1'b0;
    iload = d;
    #1;
    chk({tag, "_iaddr"}, iaddr, exp_addr);
    $display("beat %s done iaddr=%h data=%h", tag, iaddr, d);
    tick();
    iwait = 1'b1;
  endtask

  // Present a missing fetch in IDLE and run the full two-beat fill.
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1, input string tag);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF8;
    dp_imemREN  = 1'b1;
    dp_imemaddr = addr;
    #1;
    chk({tag, "_miss"}, 32'(dp_ihit), 32'd0);
    chk({tag, "_idle_iren"}, 32'(iREN), 32'd0);
    $display("miss %s addr=%h", tag, addr);
    tick();
    beat(2, d0, base, {tag, "_b0"});
    beat(2, d1, base + 32'd4, {tag, "_b1"});
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ihit", 32'(dp_ihit), 32'd0);
    chk("rst_load", dp_imemload, 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    tick();
    tick();
    RST = 1'b0;

    // First miss at 0x40, post-fill hit one cycle after the second beat
    miss_fill(32'h40, 32'h1111_1111, 32'h2222_2222, "fill40");
    #1;
    chk("post_fill_hit", 32'(dp_ihit), 32'd1);
    chk("post_fill_load", dp_imemload, 32'h1111_1111);
    chk("post_fill_iren", 32'(iREN), 32'd0);
    chk("miss_cnt_1", miss_count, 32'd1);
    chk("hit_cnt_0", hit_count, 32'd0);
    $display("post-fill hit load=%h", dp_imemload);
    tick();
    chk("hit_cnt_1", hit_count, 32'd1);

    // Same-block fetch of 0x44 held for three cycles
    dp_imemaddr = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hit44", 32'(dp_ihit), 32'd1);
      chk("load44", dp_imemload, 32'h2222_2222);
      $display("hold 0x44 cycle %0d load=%h", i, dp_imemload);
      tick();
      chk("hit_cnt_hold", hit_count, 32'(2 + i));
    end
    dp_imemREN = 1'b0;
    #1;
    chk("noren_ihit", 32'(dp_ihit), 32'd0);
    chk("noren_load", dp_imemload, 32'd0);
    tick();
    chk("hit_cnt_idle", hit_count, 32'd4);

    // Conflict: 0x80 evicts 0x40, then 0x40 misses again
    miss_fill(32'h80, 32'hA0A0_A0A0, 32'hA1A1_A1A1, "fill80");
    #1;
    chk("hit80", 32'(dp_ihit), 32'd1);
    chk("load80", dp_imemload, 32'hA0A0_A0A0);
    tick();
    miss_fill(32'h40, 32'h1111_1111, 32'h2222_2222, "refill40");
    #1;
    chk("miss_cnt_3", miss_count, 32'd3);
    chk("rehit40", dp_imemload, 32'h1111_1111);
    tick();

    // Address change and REN drop during a fill of 0x40
    miss_fill(32'h80, 32'hA0A0_A0A0, 32'hA1A1_A1A1, "fill80b");
    #1;
    dp_imemaddr = 32'h40;
    #1;
    chk("mid_miss40", 32'(dp_ihit), 32'd0);
    tick();
    dp_imemaddr = 32'h100;
    beat(2, 32'hB0B0_B0B0, 32'h40, "mid_b0");
    dp_imemREN = 1'b0;
    beat(2, 32'hB1B1_B1B1, 32'h44, "mid_b1");
    dp_imemREN  = 1'b1;
    dp_imemaddr = 32'h44;
    #1;
    chk("mid_hit44", 32'(dp_ihit), 32'd1);
    chk("mid_load44", dp_imemload, 32'hB1B1_B1B1);
    chk("miss_cnt_5", miss_count, 32'd5);
    tick();
    miss_fill(32'h100, 32'hC0C0_C0C0, 32'hC1C1_C1C1, "fill100");
    #1;
    chk("hit100", 32'(dp_ihit), 32'd1);
    chk("load100", dp_imemload, 32'hC0C0_C0C0);
    chk("miss_cnt_6", miss_count, 32'd6);
    tick();

    // Reset asserted during FILL1
    dp_imemaddr = 32'h40;
    #1;
    chk("rf_miss40", 32'(dp_ihit), 32'd0);
    tick();
    beat(2, 32'hD0D0_D0D0, 32'h40, "rf_b0");
    iwait = 1'b1;
    #1;
    chk("rf_fill1_iren", 32'(iREN), 32'd1);
    chk("rf_fill1_iaddr", iaddr, 32'h44);
    RST = 1'b1;
    #1;
    chk("rf_iren_drop", 32'(iREN), 32'd0);
    chk("rf_iaddr_zero", iaddr, 32'd0);
    chk("rf_hits_zero", hit_count, 32'd0);
    chk("rf_misses_zero", miss_count, 32'd0);
    chk("rf_ihit_zero", 32'(dp_ihit), 32'd0);
    $display("reset during fill1 iREN=%0d", iREN);
    tick();
    RST = 1'b0;
    dp_imemaddr = 32'h100;
    #1;
    chk("rf_miss100", 32'(dp_ihit), 32'd0);
    dp_imemaddr = 32'h40;
    #1;
    chk("rf_miss40_again", 32'(dp_ihit), 32'd0);
    tick();
    chk("rf_miss_cnt_1", miss_count, 32'd1);

    // Long arbiter stall in FILL0
    for (int i = 0; i < 20; i++) begin
      iwait = 1'b1;
      dp_imemaddr = 32'h200 + 32'(i * 8);
      #1;
      chk("stall_iren", 32'(iREN), 32'd1);
      chk("stall_iaddr", iaddr, 32'h40);
      chk("stall_ihit", 32'(dp_ihit), 32'd0);
      $display("stall cycle %0d iREN=%0d iaddr=%h", i, iREN, iaddr);
      tick();
    end
    chk("stall_miss_cnt", miss_count, 32'd1);
    beat(0, 32'hE0E0_E0E0, 32'h40, "stall_b0");
    beat(1, 32'hE1E1_E1E1, 32'h44, "stall_b1");
    dp_imemaddr = 32'h44;
    #1;
    chk("stall_hit44", 32'(dp_ihit), 32'd1);
    chk("stall_load44", dp_imemload, 32'hE1E1_E1E1);
    tick();
    chk("stall_hit_cnt", hit_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
